// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32 datapath (lw/sw, R-type, addi/andi/ori, beq/bne).
// Define ILLEGAL_TRAP_EN to trap unknown opcodes and unsupported functs into a sticky HALT state.
module multicycle_control_fsm #(
   parameter int MEM_WAIT = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       zero,
   output logic       PCWrite,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic       PCSource,
   output logic       RegWrite,
   output logic [3:0] ALUControl,
   output logic [3:0] state,
   output logic       illegal
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC_R = 4'd6,
      S_ALUWB  = 4'd7,
      S_EXEC_I = 4'd8,
      S_BRANCH = 4'd9,
      S_HALT   = 4'd10
   } state_t;

   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_NONE = 4'b1111;

   localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

   state_t     cur_state;
   state_t     next_state;
   logic [2:0] wait_cnt;
   logic       wait_done;
   logic       mem_state;

   function automatic logic [3:0] r_alu(input logic [2:0] f3, input logic f7);
      case (f3)
         3'b000:  r_alu = f7 ? ALU_SUB : ALU_ADD;
         3'b111:  r_alu = ALU_AND;
         3'b110:  r_alu = ALU_OR;
         default: r_alu = ALU_NONE;
      endcase
   endfunction

   function automatic logic [3:0] i_alu(input logic [2:0] f3);
      case (f3)
         3'b000:  i_alu = ALU_ADD;
         3'b111:  i_alu = ALU_AND;
         3'b110:  i_alu = ALU_OR;
         default: i_alu = ALU_NONE;
      endcase
   endfunction

   // Memory-access states hold until the stall counter reaches MEM_WAIT.
   assign mem_state = (cur_state == S_FETCH) || (cur_state == S_MEMRD) || (cur_state == S_MEMWR);
   assign wait_done = (wait_cnt == WAIT_LAST);
   assign state     = cur_state;

`ifdef ILLEGAL_TRAP_EN
   logic illegal_q;
   assign illegal = illegal_q;
`else
   assign illegal = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= S_FETCH;
         wait_cnt  <= 3'd0;
`ifdef ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         cur_state <= next_state;
         if (mem_state && !wait_done)
            wait_cnt <= wait_cnt + 3'd1;
         else
            wait_cnt <= 3'd0;
`ifdef ILLEGAL_TRAP_EN
         if (next_state == S_HALT)
            illegal_q <= 1'b1;
`endif
      end
   end

   always_comb begin
      next_state = cur_state;
      case (cur_state)
         S_FETCH:  if (wait_done) next_state = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: next_state = S_MEMADR;
               OP_R:         next_state = S_EXEC_R;
               OP_I:         next_state = S_EXEC_I;
               OP_BR:        next_state = S_BRANCH;
`ifdef ILLEGAL_TRAP_EN
               default:      next_state = S_HALT;
`else
               default:      next_state = S_FETCH;
`endif
            endcase
         end
         S_MEMADR: next_state = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (wait_done) next_state = S_MEMWB;
         S_MEMWB:  next_state = S_FETCH;
         S_MEMWR:  if (wait_done) next_state = S_FETCH;
`ifdef ILLEGAL_TRAP_EN
         S_EXEC_R: next_state = (r_alu(funct3, funct7b5) == ALU_NONE) ? S_HALT : S_ALUWB;
         S_EXEC_I: next_state = (i_alu(funct3) == ALU_NONE) ? S_HALT : S_ALUWB;
`else
         S_EXEC_R: next_state = S_ALUWB;
         S_EXEC_I: next_state = S_ALUWB;
`endif
         S_ALUWB:  next_state = S_FETCH;
         S_BRANCH: next_state = S_FETCH;
         S_HALT:   next_state = S_HALT;
         default:  next_state = S_FETCH;
      endcase
   end

   // Reset overrides every control output, so an interrupted store never completes.
   always_comb begin
      PCWrite    = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      PCSource   = 1'b0;
      RegWrite   = 1'b0;
      ALUControl = ALU_ADD;
      if (!reset) begin
         case (cur_state)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = wait_done;
               PCWrite = wait_done;
            end
            S_DECODE: ALUSrcB = 2'b10;
            S_MEMADR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
               IorD    = 1'b1;
               MemRead = 1'b1;
            end
            S_MEMWB: begin
               MemtoReg = 1'b1;
               RegWrite = 1'b1;
            end
            S_MEMWR: begin
               IorD     = 1'b1;
               MemWrite = wait_done;
            end
            S_EXEC_R: begin
               ALUSrcA    = 1'b1;
               ALUControl = r_alu(funct3, funct7b5);
            end
            S_EXEC_I: begin
               ALUSrcA    = 1'b1;
               ALUSrcB    = 2'b10;
               ALUControl = i_alu(funct3);
            end
            S_ALUWB: RegWrite = 1'b1;
            S_BRANCH: begin
               ALUSrcA    = 1'b1;
               PCSource   = 1'b1;
               ALUControl = ALU_SUB;
               case (funct3)
                  3'b000:  PCWrite = zero;
                  3'b001:  PCWrite = ~zero;
                  default: PCWrite = 1'b0;
               endcase
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: three instances with MEM_WAIT = 0, 1, 2 share inputs.
// Honors ILLEGAL_TRAP_EN so the illegal-opcode vectors match the build under test.
module tb_multicycle_control_fsm;

   // {PCWrite,IorD,MemRead,MemWrite,IRWrite,MemtoReg,ALUSrcA} {ALUSrcB} {PCSource,RegWrite} {ALUControl} {state} {illegal}
   typedef struct packed {
      logic [6:0] g7;
      logic [1:0] asb;
      logic [1:0] pr;
      logic [3:0] alu;
      logic [3:0] st;
      logic       ill;
   } ctrl_t;

   typedef struct {
      logic       rst;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7;
      logic       z;
      ctrl_t      exp;
      string      name;
   } vec_t;

   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_SW = 7'b0100011;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_BR = 7'b1100011;
   localparam logic [6:0] OP_BAD = 7'b1111111;

   localparam ctrl_t RST    = {7'b0000000, 2'b00, 2'b00, 4'b0010, 4'd0, 1'b0};
   localparam ctrl_t F_LAST = {7'b1010100, 2'b01, 2'b00, 4'b0010, 4'd0, 1'b0};
   localparam ctrl_t F_WAIT = {7'b0010000, 2'b01, 2'b00, 4'b0010, 4'd0, 1'b0};
   localparam ctrl_t DEC    = {7'b0000000, 2'b10, 2'b00, 4'b0010, 4'd1, 1'b0};
   localparam ctrl_t MADR   = {7'b0000001, 2'b10, 2'b00, 4'b0010, 4'd2, 1'b0};
   localparam ctrl_t MRD    = {7'b0110000, 2'b00, 2'b00, 4'b0010, 4'd3, 1'b0};
   localparam ctrl_t MWB    = {7'b0000010, 2'b00, 2'b01, 4'b0010, 4'd4, 1'b0};
   localparam ctrl_t MWR_W  = {7'b0100000, 2'b00, 2'b00, 4'b0010, 4'd5, 1'b0};
   localparam ctrl_t MWR_L  = {7'b0101000, 2'b00, 2'b00, 4'b0010, 4'd5, 1'b0};
   localparam ctrl_t AWB    = {7'b0000000, 2'b00, 2'b01, 4'b0010, 4'd7, 1'b0};
   localparam ctrl_t HALTED = {7'b0000000, 2'b00, 2'b00, 4'b0010, 4'd10, 1'b1};
   localparam ctrl_t RST_IN_MWR = {7'b0000000, 2'b00, 2'b00, 4'b0010, 4'd5, 1'b0};

   function automatic ctrl_t exr(input logic [3:0] alu);
      exr = {7'b0000001, 2'b00, 2'b00, alu, 4'd6, 1'b0};
   endfunction

   function automatic ctrl_t exi(input logic [3:0] alu);
      exi = {7'b0000001, 2'b10, 2'b00, alu, 4'd8, 1'b0};
   endfunction

   function automatic ctrl_t br(input logic pcw);
      br = {pcw, 5'b00000, 1'b1, 2'b00, 2'b10, 4'b0110, 4'd9, 1'b0};
   endfunction

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = 7'd0;
   logic [2:0] funct3 = 3'd0;
   logic       funct7b5 = 1'b0;
   logic       zero = 1'b0;
   ctrl_t      obs [3];

   int tests = 0;
   int fails = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      logic       pc_write, ior_d, mem_read, mem_write, ir_write, memto_reg, alu_src_a;
      logic [1:0] alu_src_b;
      logic       pc_source, reg_write, ill;
      logic [3:0] alu_control, st;

      multicycle_control_fsm #(.MEM_WAIT(g)) dut (
         .clk        (clk),
         .reset      (reset),
         .opcode     (opcode),
         .funct3     (funct3),
         .funct7b5   (funct7b5),
         .zero       (zero),
         .PCWrite    (pc_write),
         .IorD       (ior_d),
         .MemRead    (mem_read),
         .MemWrite   (mem_write),
         .IRWrite    (ir_write),
         .MemtoReg   (memto_reg),
         .ALUSrcA    (alu_src_a),
         .ALUSrcB    (alu_src_b),
         .PCSource   (pc_source),
         .RegWrite   (reg_write),
         .ALUControl (alu_control),
         .state      (st),
         .illegal    (ill)
      );

      assign obs[g] = {pc_write, ior_d, mem_read, mem_write, ir_write, memto_reg, alu_src_a,
                       alu_src_b, pc_source, reg_write, alu_control, st, ill};
   end

   task automatic applyStimulus(input logic rst, input logic [6:0] op, input logic [2:0] f3,
                                input logic f7, input logic z);
      reset    = rst;
      opcode   = op;
      funct3   = f3;
      funct7b5 = f7;
      zero     = z;
   endtask

   task automatic checkOutput(input int idx, input ctrl_t exp, input string name);
      tests++;
      if (obs[idx] !== exp) begin
         fails++;
         $display("[TB] FAIL %s (MEM_WAIT=%0d): got %b_%b_%b_%b_%0d_%b, expected %b_%b_%b_%b_%0d_%b",
                  name, idx, obs[idx].g7, obs[idx].asb, obs[idx].pr, obs[idx].alu, obs[idx].st,
                  obs[idx].ill, exp.g7, exp.asb, exp.pr, exp.alu, exp.st, exp.ill);
      end
   endtask

   task automatic addVec(input logic rst, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic z, input ctrl_t exp, input string name);
      vec_t v;
      v.rst = rst; v.op = op; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   // One cycle for one instance: drive after the edge, sample at the falling edge.
   task automatic stepCheck(input int idx, input ctrl_t exp, input string name);
      @(negedge clk);
      checkOutput(idx, exp, name);
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReset();
      applyStimulus(1'b1, 7'd0, 3'd0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int x5;
      ctrl_t seq_lw [10];
      ctrl_t seq_sw [7];

      addVec(1, OP_I, 3'b000, 0, 0, RST, "reset_hold1");
      addVec(1, OP_I, 3'b000, 0, 0, RST, "reset_hold2");
      addVec(0, OP_I, 3'b000, 0, 0, F_LAST, "first_fetch");
      addVec(0, OP_I, 3'b000, 0, 0, DEC, "addi4_dec");
      addVec(0, OP_I, 3'b000, 0, 0, exi(4'b0010), "addi4_exec");
      addVec(0, OP_I, 3'b000, 0, 0, AWB, "addi4_wb");
      x5 = 4;
      for (int it = 0; it < 4; it++) begin
         addVec(0, OP_I, 3'b000, 0, 0, F_LAST, "dec_fetch");
         addVec(0, OP_I, 3'b000, 0, 0, DEC, "dec_decode");
         addVec(0, OP_I, 3'b000, 0, 0, exi(4'b0010), "dec_exec");
         addVec(0, OP_I, 3'b000, 0, 0, AWB, "dec_wb");
         x5--;
         addVec(0, OP_BR, 3'b000, 0, x5 == 0, F_LAST, "beq_exit_fetch");
         addVec(0, OP_BR, 3'b000, 0, x5 == 0, DEC, "beq_exit_dec");
         addVec(0, OP_BR, 3'b000, 0, x5 == 0, br(x5 == 0), "beq_exit_branch");
         if (x5 != 0) begin
            addVec(0, OP_BR, 3'b000, 0, 1, F_LAST, "beq_back_fetch");
            addVec(0, OP_BR, 3'b000, 0, 1, DEC, "beq_back_dec");
            addVec(0, OP_BR, 3'b000, 0, 1, br(1'b1), "beq_back_branch");
         end
      end
      addVec(0, OP_BR, 3'b001, 0, 1, F_LAST, "bne_fetch");
      addVec(0, OP_BR, 3'b001, 0, 1, DEC, "bne_dec");
      addVec(0, OP_BR, 3'b001, 0, 1, br(1'b0), "bne_zero1");
      addVec(0, OP_BR, 3'b001, 0, 0, F_LAST, "bne_fetch2");
      addVec(0, OP_BR, 3'b001, 0, 0, DEC, "bne_dec2");
      addVec(0, OP_BR, 3'b001, 0, 0, br(1'b1), "bne_zero0");
      addVec(0, OP_BR, 3'b100, 0, 1, F_LAST, "blt_fetch");
      addVec(0, OP_BR, 3'b100, 0, 1, DEC, "blt_dec");
      addVec(0, OP_BR, 3'b100, 0, 1, br(1'b0), "unsupported_branch");
      addVec(0, OP_R, 3'b000, 1, 0, F_LAST, "sub_fetch");
      addVec(0, OP_R, 3'b000, 1, 0, DEC, "sub_dec");
      addVec(0, OP_R, 3'b000, 1, 0, exr(4'b0110), "sub_exec");
      addVec(0, OP_R, 3'b000, 1, 0, AWB, "sub_wb");
      addVec(0, OP_R, 3'b110, 0, 0, F_LAST, "or_fetch");
      addVec(0, OP_R, 3'b110, 0, 0, DEC, "or_dec");
      addVec(0, OP_R, 3'b110, 0, 0, exr(4'b0001), "or_exec");
      addVec(0, OP_R, 3'b110, 0, 0, AWB, "or_wb");
      addVec(0, OP_R, 3'b111, 0, 0, F_LAST, "and_fetch");
      addVec(0, OP_R, 3'b111, 0, 0, DEC, "and_dec");
      addVec(0, OP_R, 3'b111, 0, 0, exr(4'b0000), "and_exec");
      addVec(0, OP_R, 3'b111, 0, 0, AWB, "and_wb");
      addVec(0, OP_R, 3'b000, 0, 0, F_LAST, "add_fetch");
      addVec(0, OP_R, 3'b000, 0, 0, DEC, "add_dec");
      addVec(0, OP_R, 3'b000, 0, 0, exr(4'b0010), "add_exec");
      addVec(0, OP_R, 3'b000, 0, 0, AWB, "add_wb");
      addVec(0, OP_I, 3'b111, 0, 0, F_LAST, "andi_fetch");
      addVec(0, OP_I, 3'b111, 0, 0, DEC, "andi_dec");
      addVec(0, OP_I, 3'b111, 0, 0, exi(4'b0000), "andi_exec");
      addVec(0, OP_I, 3'b111, 0, 0, AWB, "andi_wb");
      addVec(0, OP_I, 3'b110, 0, 0, F_LAST, "ori_fetch");
      addVec(0, OP_I, 3'b110, 0, 0, DEC, "ori_dec");
      addVec(0, OP_I, 3'b110, 0, 0, exi(4'b0001), "ori_exec");
      addVec(0, OP_I, 3'b110, 0, 0, AWB, "ori_wb");
      addVec(0, OP_LW, 3'b010, 0, 0, F_LAST, "lw_fetch");
      addVec(0, OP_LW, 3'b010, 0, 0, DEC, "lw_dec");
      addVec(0, OP_LW, 3'b010, 0, 0, MADR, "lw_memadr");
      addVec(0, OP_LW, 3'b010, 0, 0, MRD, "lw_memrd");
      addVec(0, OP_LW, 3'b010, 0, 0, MWB, "lw_memwb");
      addVec(0, OP_SW, 3'b010, 0, 0, F_LAST, "sw_fetch");
      addVec(0, OP_SW, 3'b010, 0, 0, DEC, "sw_dec");
      addVec(0, OP_SW, 3'b010, 0, 0, MADR, "sw_memadr");
      addVec(0, OP_SW, 3'b010, 0, 0, MWR_L, "sw_memwr");
      addVec(0, OP_BAD, 3'b000, 0, 0, F_LAST, "bad_fetch");
      addVec(0, OP_BAD, 3'b000, 0, 0, DEC, "bad_dec");
`ifdef ILLEGAL_TRAP_EN
      addVec(0, OP_BAD, 3'b000, 0, 0, HALTED, "bad_halt");
      addVec(0, OP_R, 3'b000, 0, 0, HALTED, "halt_sticky");
      addVec(1, OP_R, 3'b000, 0, 0, HALTED, "halt_reset_pre_edge");
      addVec(1, OP_R, 3'b000, 0, 0, RST, "halt_reset_cleared");
      addVec(0, OP_I, 3'b010, 0, 0, F_LAST, "slti_fetch");
      addVec(0, OP_I, 3'b010, 0, 0, DEC, "slti_dec");
      addVec(0, OP_I, 3'b010, 0, 0, exi(4'b1111), "slti_exec");
      addVec(0, OP_I, 3'b010, 0, 0, HALTED, "slti_trap");
`else
      addVec(0, OP_BAD, 3'b000, 0, 0, F_LAST, "bad_nop_fetch");
      addVec(0, OP_I, 3'b010, 0, 0, DEC, "slti_dec");
      addVec(0, OP_I, 3'b010, 0, 0, exi(4'b1111), "slti_exec");
      addVec(0, OP_I, 3'b010, 0, 0, AWB, "slti_wb");
`endif

      @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].z);
         stepCheck(0, vecs[i].exp, $sformatf("%s[%0d]", vecs[i].name, i));
      end

      // lw with two stall cycles per memory state: 9 cycles, then back to FETCH.
      seq_lw = '{F_WAIT, F_WAIT, F_LAST, DEC, MADR, MRD, MRD, MRD, MWB, F_WAIT};
      pulseReset();
      applyStimulus(1'b0, OP_LW, 3'b010, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++)
         stepCheck(2, seq_lw[i], $sformatf("lw_wait2[%0d]", i));

      // sw with one stall cycle: MemWrite only on the second MEMWR cycle.
      seq_sw = '{F_WAIT, F_LAST, DEC, MADR, MWR_W, MWR_L, F_WAIT};
      pulseReset();
      applyStimulus(1'b0, OP_SW, 3'b010, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++)
         stepCheck(1, seq_sw[i], $sformatf("sw_wait1[%0d]", i));

      // Reset landing in the MEMWR stall cycle must suppress the write and clear the counter.
      pulseReset();
      applyStimulus(1'b0, OP_SW, 3'b010, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++)
         stepCheck(1, seq_sw[i], $sformatf("sw_abort[%0d]", i));
      applyStimulus(1'b1, OP_SW, 3'b010, 1'b0, 1'b0);
      stepCheck(1, RST_IN_MWR, "sw_abort_reset_pre_edge");
      stepCheck(1, RST, "sw_abort_reset_cleared");
      applyStimulus(1'b0, OP_SW, 3'b010, 1'b0, 1'b0);
      stepCheck(1, F_WAIT, "sw_abort_refetch0");
      stepCheck(1, F_LAST, "sw_abort_refetch1");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
